// File: rtl/leading_count_unit_if.sv
// Operand/result bundle for the leading count unit.
//
// Handshake: the master raises start with mode and a. The slave accepts the request
// at any rising edge where busy is low, and ignores start while busy is high. done is a
// one-cycle pulse. result and all_match are valid from that pulse and hold their values
// until the next done.
interface leading_count_unit_if #(
  parameter int WIDTH = 32
) ();
  localparam int RW = $clog2(WIDTH + 1);

  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic             busy;
  logic             done;
  logic [RW-1:0]    result;
  logic             all_match;

  modport master (
    output start, mode, a,
    input  busy, done, result, all_match
  );

  modport slave (
    input  start, mode, a,
    output busy, done, result, all_match
  );
endinterface

// File: rtl/leading_count_unit.sv
// Multi-cycle leading-zero / leading-one counter. Each scan cycle examines STEP bits,
// starting from the MSB. CLO is handled as CLZ of the inverted operand, so the scan
// always looks for the first 1. A scan stops at the first chunk that holds a 1, or
// after N chunks.
module leading_count_unit #(
  parameter int WIDTH = 32,
  parameter int STEP  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  leading_count_unit_if.slave  bus,
  output logic [1:0]           dbg_state
);
  localparam int N  = WIDTH / STEP;
  localparam int RW = $clog2(WIDTH + 1);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [RW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [RW-1:0]    result_q, result_d;
  logic             all_match_q, all_match_d;

  logic [STEP-1:0]  chunk;
  logic [RW-1:0]    chunk_lz;
  logic             chunk_hit;

  // Count the leading zeros of the chunk at the top of the shift register
  always_comb begin
    chunk     = sh_q[WIDTH-1 -: STEP];
    chunk_lz  = '0;
    chunk_hit = 1'b0;
    for (int i = STEP - 1; i >= 0; i--) begin
      if (!chunk_hit) begin
        if (chunk[i]) chunk_hit = 1'b1;
        else          chunk_lz  = chunk_lz + RW'(1);
      end
    end
  end

  // Next-state logic. DONE accepts a new start exactly as IDLE does
  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    result_d    = result_q;
    all_match_d = all_match_q;
    case (state_q)
      S_SCAN: begin
        if (chunk_hit) begin
          cnt_d       = cnt_q + chunk_lz;
          result_d    = cnt_q + chunk_lz;
          all_match_d = 1'b0;
          state_d     = S_DONE;
        end else if (idx_q == IW'(N - 1)) begin
          // The last chunk is also empty, so the whole operand matched
          cnt_d       = RW'(WIDTH);
          result_d    = RW'(WIDTH);
          all_match_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q + RW'(STEP);
          sh_d  = sh_q << STEP;
          idx_d = idx_q + IW'(1);
        end
      end
      default: begin
        if (bus.start) begin
          sh_d    = bus.mode ? ~bus.a : bus.a;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_SCAN;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
    busy_d = (state_d == S_SCAN);
    done_d = (state_d == S_DONE);
  end

  // State and registered outputs; reset aborts any scan without a done pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sh_q        <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      all_match_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_q    <= result_d;
      all_match_q <= all_match_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.all_match = all_match_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_leading_count_unit.sv
// Bench for leading_count_unit at WIDTH=32, STEP=8: directed scenarios plus random operands.
module tb_leading_count_unit;
  localparam int W    = 32;
  localparam int STEP = 8;
  localparam int N    = W / STEP;
  localparam int RW   = $clog2(W + 1);

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         chk_cnt;
  int         err_cnt;
  logic [RW:0] exp_q[$];
  logic [RW:0] last_res;

  leading_count_unit_if #(.WIDTH(W)) bus ();

  leading_count_unit #(.WIDTH(W), .STEP(STEP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: leading count taken straight from the bit definition
  function automatic int ref_lead(input logic [W-1:0] v, input logic m);
    logic [W-1:0] x;
    int n;
    bit found;
    x = m ? ~v : v;
    n = 0;
    found = 0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!found) begin
        if (x[i]) found = 1;
        else n++;
      end
    end
    return n;
  endfunction

  // Issue one operation from IDLE/DONE and follow it through to done.
  // While busy, a/mode are scrambled and start is toggled, none of which may matter.
  task automatic run_op(input logic [W-1:0] av, input logic mv, input bit hold);
    int lat;
    int exp_cnt;
    int exp_lat;
    logic [RW:0] e;
    exp_cnt = ref_lead(av, mv);
    exp_lat = (exp_cnt == W) ? N : exp_cnt / STEP + 1;
    bus.a     = av;
    bus.mode  = mv;
    bus.start = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back({(exp_cnt == W), RW'(exp_cnt)});
    check_eq("busy_after_start", 64'(bus.busy), 64'd1);
    check_eq("done_after_start", 64'(bus.done), 64'd0);
    lat = 0;
    do begin
      bus.a    = $urandom;
      bus.mode = 1'($urandom_range(0, 1));
      if (!hold) bus.start = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      lat++;
      if (!bus.done) check_eq("busy_in_scan", 64'(bus.busy), 64'd1);
    end while (!bus.done && lat < N + 2);
    check_eq("done_seen", 64'(bus.done), 64'd1);
    check_eq("latency", 64'(lat), 64'(exp_lat));
    check_eq("busy_in_done", 64'(bus.busy), 64'd0);
    e = exp_q.pop_front();
    check_eq("result", 64'(bus.result), 64'(e[RW-1:0]));
    check_eq("all_match", 64'(bus.all_match), 64'(e[RW]));
    last_res = e;
    if (!hold) bus.start = 1'b0;
  endtask

  // Idle cycles: no done pulse, outputs hold the last result
  task automatic idle(input int n);
    bus.start = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      check_eq("idle_done", 64'(bus.done), 64'd0);
      check_eq("idle_busy", 64'(bus.busy), 64'd0);
      check_eq("hold_result", 64'(bus.result), 64'(last_res[RW-1:0]));
      check_eq("hold_all_match", 64'(bus.all_match), 64'(last_res[RW]));
    end
  endtask

  initial begin
    logic [W-1:0] av;
    logic         mv;
    chk_cnt   = 0;
    err_cnt   = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.mode  = 1'b0;
    bus.a     = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_done", 64'(bus.done), 64'd0);
    check_eq("rst_result", 64'(bus.result), 64'd0);
    check_eq("rst_all_match", 64'(bus.all_match), 64'd0);
    rst_n    = 1'b1;
    last_res = '0;
    idle(2);

    // Directed scenarios
    run_op(32'h8000_0000, 1'b0, 0);
    idle(2);
    run_op(32'h0000_0001, 1'b0, 0);
    run_op(32'h0001_0000, 1'b0, 0);
    idle(1);
    run_op(32'h0000_0000, 1'b0, 0);
    run_op(32'hFFFF_FFFF, 1'b1, 0);
    idle(1);
    run_op(32'hFFFF_0F00, 1'b1, 0);
    idle(1);

    // Start held high: each done is followed directly by a new scan
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) run_op(32'h0001_0000, 1'b0, 1);
      else            run_op(32'hFFFF_0F00, 1'b1, 1);
    end
    idle(2);

    // Reset during the second scan cycle aborts without a done pulse
    run_op(32'h00F0_0000, 1'b0, 0);
    bus.a     = '0;
    bus.mode  = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("abort_busy", 64'(bus.busy), 64'd0);
    check_eq("abort_done", 64'(bus.done), 64'd0);
    check_eq("abort_result", 64'(bus.result), 64'd0);
    check_eq("abort_all_match", 64'(bus.all_match), 64'd0);
    rst_n    = 1'b1;
    last_res = '0;
    idle(4);
    run_op(32'h0000_0100, 1'b0, 0);
    idle(1);

    // Random operands spread across every latency
    for (int i = 0; i < 60; i++) begin
      av = $urandom;
      av = av >> $urandom_range(0, 32);
      mv = 1'($urandom_range(0, 1));
      if (mv) av = ~av;
      run_op(av, mv, 0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
